// File: rtl/safety_island_boot_pkg.sv
// safety_island_boot_pkg: shared states and register-map constants for the boot sequencer
package safety_island_boot_pkg;
  typedef enum logic [3:0] {
    S_IDLE, S_DELAY, S_WR_BOOTMODE, S_WR_ENTRY, S_WR_FETCH,
    S_POLL_WAIT, S_POLL_RD, S_DONE, S_ERROR
  } state_e;
  localparam logic [31:0] BOOT_MODE_ADDR = 32'h0000_00C8;
  localparam logic [31:0] ENTRY_ADDR = 32'h0000_0004;
  localparam logic [31:0] FETCH_EN_ADDR = 32'h0000_0008;
  localparam logic [31:0] EOC_ADDR = 32'h0000_00A0;
  localparam int EOC_BIT = 31;
  localparam logic [30:0] TIMEOUT_STATUS = 31'h7FFF_FFFF;
endpackage

// File: rtl/safety_island_boot_reg_xfer.sv
// safety_island_boot_reg_xfer: single-transaction register-bus master with registered request
module safety_island_boot_reg_xfer #(
  parameter int AddrWidth = 32,
  parameter int DataWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 issue,
  input  logic [AddrWidth-1:0] addr,
  input  logic                 write,
  input  logic [DataWidth-1:0] wdata,
  output logic                 reg_req_o,
  output logic [AddrWidth-1:0] reg_addr_o,
  output logic                 reg_write_o,
  output logic [DataWidth-1:0] reg_wdata_o,
  output logic [3:0]           reg_wstrb_o,
  input  logic                 reg_ready_i,
  input  logic [DataWidth-1:0] reg_rdata_i,
  input  logic                 reg_error_i,
  output logic                 xfer_done,
  output logic [DataWidth-1:0] rdata,
  output logic                 error
);
  // a new issue on the completing edge wins, giving back-to-back transfers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      reg_req_o   <= 1'b0;
      reg_addr_o  <= '0;
      reg_write_o <= 1'b0;
      reg_wdata_o <= '0;
      reg_wstrb_o <= 4'h0;
    end else if (issue) begin
      reg_req_o   <= 1'b1;
      reg_addr_o  <= addr;
      reg_write_o <= write;
      reg_wdata_o <= wdata;
      reg_wstrb_o <= 4'hF;
    end else if (reg_ready_i) begin
      reg_req_o   <= 1'b0;
    end
  end
  assign xfer_done = reg_req_o && reg_ready_i;
  assign rdata = reg_rdata_i;
  assign error = reg_error_i;
endmodule

// File: rtl/safety_island_boot_ctrl.sv
// safety_island_boot_ctrl: boot sequencer writing bootmode/entry/fetch-enable then polling EOC
// Optional EOC polling timeout enabled by defining SAFETY_BOOT_TIMEOUT_EN.
module safety_island_boot_ctrl
  import safety_island_boot_pkg::*;
#(
  parameter int                   AddrWidth    = 32,
  parameter int                   DataWidth    = 32,
  parameter logic [AddrWidth-1:0] BootModeAddr = AddrWidth'(BOOT_MODE_ADDR),
  parameter logic [AddrWidth-1:0] EntryAddr    = AddrWidth'(ENTRY_ADDR),
  parameter logic [AddrWidth-1:0] FetchEnAddr  = AddrWidth'(FETCH_EN_ADDR),
  parameter logic [AddrWidth-1:0] EocAddr      = AddrWidth'(EOC_ADDR),
  parameter int                   StartDelay   = 1000,
  parameter int                   PollInterval = 64
`ifdef SAFETY_BOOT_TIMEOUT_EN
  , parameter logic [31:0]        TimeoutCycles = 32'd10_000_000
`endif
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [DataWidth-1:0] bootmode_i,
  input  logic [DataWidth-1:0] entry_point_i,
  output logic                 reg_req_o,
  output logic [AddrWidth-1:0] reg_addr_o,
  output logic                 reg_write_o,
  output logic [DataWidth-1:0] reg_wdata_o,
  output logic [3:0]           reg_wstrb_o,
  input  logic                 reg_ready_i,
  input  logic [DataWidth-1:0] reg_rdata_i,
  input  logic                 reg_error_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [30:0]          exit_status_o,
  output logic                 error_o
);
  localparam logic [31:0] DelayLast = 32'(StartDelay - 1);
  localparam logic [31:0] PollLast = 32'(PollInterval - 1);
  state_e state, next;
  logic [31:0] cnt;
  logic [DataWidth-1:0] bootmode_q, entry_q, iss_wdata, rdata;
  logic [AddrWidth-1:0] iss_addr;
  logic [30:0] status_q;
  logic issue, iss_write, xdone, xerr, start_cap, eoc_hit, to_err, timeout;
  safety_island_boot_reg_xfer #(.AddrWidth(AddrWidth), .DataWidth(DataWidth)) u_xfer (
    .clk_i(clk_i), .rst_i(rst_i), .issue(issue), .addr(iss_addr), .write(iss_write),
    .wdata(iss_wdata), .reg_req_o(reg_req_o), .reg_addr_o(reg_addr_o),
    .reg_write_o(reg_write_o), .reg_wdata_o(reg_wdata_o), .reg_wstrb_o(reg_wstrb_o),
    .reg_ready_i(reg_ready_i), .reg_rdata_i(reg_rdata_i), .reg_error_i(reg_error_i),
    .xfer_done(xdone), .rdata(rdata), .error(xerr)
  );
  assign start_cap = start_i && (state inside {S_IDLE, S_DONE, S_ERROR});
  assign eoc_hit = state == S_POLL_RD && xdone && !xerr && rdata[EOC_BIT];
  always_comb begin
    next = state;
    issue = 1'b0;
    iss_addr = EocAddr;
    iss_write = 1'b1;
    iss_wdata = DataWidth'(1);
    to_err = 1'b0;
    case (state)
      S_IDLE, S_DONE, S_ERROR: next = start_i ? S_DELAY : state;
      S_DELAY: if (cnt == DelayLast) begin
        next = S_WR_BOOTMODE;
        issue = 1'b1;
        iss_addr = BootModeAddr;
        iss_wdata = bootmode_q;
      end
      S_WR_BOOTMODE: if (xdone) begin
        next = xerr ? S_ERROR : S_WR_ENTRY;
        issue = !xerr;
        iss_addr = EntryAddr;
        iss_wdata = entry_q;
      end
      S_WR_ENTRY: if (xdone) begin
        next = xerr ? S_ERROR : S_WR_FETCH;
        issue = !xerr;
        iss_addr = FetchEnAddr;
      end
      S_WR_FETCH: if (xdone) next = xerr ? S_ERROR : S_POLL_WAIT;
      S_POLL_WAIT: if (timeout) begin
        next = S_ERROR;
        to_err = 1'b1;
      end else if (cnt == PollLast) begin
        next = S_POLL_RD;
        issue = 1'b1;
        iss_write = 1'b0;
        iss_wdata = '0;
      end
      S_POLL_RD: if (xdone) begin
        next = xerr ? S_ERROR : rdata[EOC_BIT] ? S_DONE : timeout ? S_ERROR : S_POLL_WAIT;
        to_err = !xerr && !rdata[EOC_BIT] && timeout;
      end
      default: next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= S_IDLE;
      cnt <= '0;
      bootmode_q <= '0;
      entry_q <= '0;
      status_q <= '0;
    end else begin
      state <= next;
      cnt <= (next != state) ? '0 : cnt + 32'd1;
      if (start_cap) begin
        bootmode_q <= bootmode_i;
        entry_q <= entry_point_i;
        status_q <= '0;
      end else if (to_err) status_q <= TIMEOUT_STATUS;
      else if (eoc_hit) status_q <= rdata[30:0];
    end
  end
`ifdef SAFETY_BOOT_TIMEOUT_EN
  logic [31:0] tcnt;
  logic tact;
  // free-runs from the first POLL_WAIT entry, holding once the limit is reached
  always_ff @(posedge clk_i) begin
    if (rst_i || start_cap) begin
      tcnt <= '0;
      tact <= 1'b0;
    end else if (state == S_POLL_WAIT || tact) begin
      tact <= 1'b1;
      if (!timeout) tcnt <= tcnt + 32'd1;
    end
  end
  assign timeout = tcnt == TimeoutCycles;
`else
  assign timeout = 1'b0;
`endif
  assign busy_o = !(state inside {S_IDLE, S_DONE, S_ERROR});
  assign done_o = state == S_DONE;
  assign error_o = state == S_ERROR;
  assign exit_status_o = status_q;
endmodule

// File: tb/tb_safety_island_boot_ctrl.sv
// tb_safety_island_boot_ctrl: directed table-driven bench for the safety island boot sequencer
module tb_safety_island_boot_ctrl;
  localparam int SD = 5;
  localparam int PI = 4;
  logic clk = 0, rst = 1, start = 0, ready = 0, rerr = 0;
  logic [31:0] bootmode = 0, entry = 0, rdata = 0;
  logic req, wr, busy, done, err;
  logic [31:0] addr, wdata;
  logic [3:0] wstrb;
  logic [30:0] status;
  int checks = 0, failures = 0, cyc = 0;
  int lat = 0, held = 0;
  bit err_en = 0;
  logic [31:0] err_addr = 0, eoc_dflt = 0;
  logic [31:0] eoc_q[$];
  typedef struct { logic [31:0] a; logic w; logic [31:0] d; logic [3:0] s; int c; logic b; } txn_t;
  txn_t log_q[$];
  typedef struct {
    logic [31:0] bm, ep; int lat, zeros; logic [31:0] eoc; logic [30:0] st;
  } vec_t;
  vec_t vt[3];

  always #5 clk = ~clk;

  safety_island_boot_ctrl #(
    .StartDelay(SD), .PollInterval(PI)
`ifdef SAFETY_BOOT_TIMEOUT_EN
    , .TimeoutCycles(32'd500)
`endif
  ) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .bootmode_i(bootmode), .entry_point_i(entry),
    .reg_req_o(req), .reg_addr_o(addr), .reg_write_o(wr), .reg_wdata_o(wdata),
    .reg_wstrb_o(wstrb), .reg_ready_i(ready), .reg_rdata_i(rdata), .reg_error_i(rerr),
    .busy_o(busy), .done_o(done), .exit_status_o(status), .error_o(err)
  );

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // bus slave: answers after lat wait cycles, logs every completed transfer
  initial forever begin
    @(negedge clk);
    if (req && !rst && held >= lat) begin
      ready = 1;
      rerr = err_en && addr == err_addr;
      rdata = wr ? 32'h0 : (eoc_q.size() > 0 ? eoc_q.pop_front() : eoc_dflt);
      log_q.push_back('{addr, wr, wdata, wstrb, cyc, busy});
      held = 0;
    end else begin
      ready = 0;
      rerr = 0;
      held = req ? held + 1 : 0;
    end
  end

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", n, a, e);
    end
  endtask

  task automatic do_start(input logic [31:0] bm, input logic [31:0] ep, output int c0);
    @(negedge clk);
    bootmode = bm;
    entry = ep;
    start = 1;
    c0 = cyc;
    @(negedge clk);
    start = 0;
    bootmode = 0;
    entry = 0;
    chk("busy_after_start", busy, 1);
    chk("done_cleared", done, 0);
    chk("error_cleared", err, 0);
  endtask

  task automatic wait_end(input int lim);
    bit ok = 0;
    for (int i = 0; i < lim && !ok; i++) begin
      @(negedge clk);
      ok = done || err;
    end
    chk("finish_in_time", ok, 1);
  endtask

  initial begin
    int c0;
    vt[0] = '{32'h1, 32'h1C00_0880, 1, 2, 32'h8000_0000, 31'h0};
    vt[1] = '{32'h0, 32'h0, 0, 0, 32'h8000_0005, 31'h5};
    vt[2] = '{32'hA5, 32'hDEAD_BEEF, 2, 1, 32'hFFFF_FFFF, 31'h7FFF_FFFF};
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("rst_req", req, 0);
    chk("rst_wstrb", wstrb, 0);
    chk("rst_addr", addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", err, 0);
    chk("rst_status", status, 0);

    for (int v = 0; v < 3; v++) begin
      lat = vt[v].lat;
      log_q.delete();
      for (int z = 0; z < vt[v].zeros; z++) eoc_q.push_back(32'h0);
      eoc_q.push_back(vt[v].eoc);
      do_start(vt[v].bm, vt[v].ep, c0);
      wait_end(500);
      chk($sformatf("v%0d_done", v), done, 1);
      chk($sformatf("v%0d_error", v), err, 0);
      chk($sformatf("v%0d_busy", v), busy, 0);
      chk($sformatf("v%0d_status", v), status, vt[v].st);
      chk($sformatf("v%0d_ntxn", v), log_q.size(), 4 + vt[v].zeros);
      if (log_q.size() == 4 + vt[v].zeros) begin
        chk($sformatf("v%0d_delay", v), log_q[0].c - c0, SD + 1 + vt[v].lat);
        chk($sformatf("v%0d_bm_addr", v), log_q[0].a, 32'hC8);
        chk($sformatf("v%0d_bm_data", v), log_q[0].d, vt[v].bm);
        chk($sformatf("v%0d_ep_addr", v), log_q[1].a, 32'h04);
        chk($sformatf("v%0d_ep_data", v), log_q[1].d, vt[v].ep);
        chk($sformatf("v%0d_fe_addr", v), log_q[2].a, 32'h08);
        chk($sformatf("v%0d_fe_data", v), log_q[2].d, 32'h1);
        for (int t = 0; t < log_q.size(); t++) begin
          chk($sformatf("v%0d_t%0d_wr", v, t), log_q[t].w, t < 3);
          chk($sformatf("v%0d_t%0d_wstrb", v, t), log_q[t].s, 4'hF);
          chk($sformatf("v%0d_t%0d_busy", v, t), log_q[t].b, 1);
          if (t >= 3) chk($sformatf("v%0d_t%0d_addr", v, t), log_q[t].a, 32'hA0);
          if (t >= 4)
            chk($sformatf("v%0d_t%0d_spacing", v, t), log_q[t].c - log_q[t-1].c, PI + 1 + vt[v].lat);
        end
      end
    end

    lat = 0;
    err_en = 1;
    err_addr = 32'h04;
    log_q.delete();
    do_start(32'h3, 32'h1000, c0);
    wait_end(100);
    chk("werr_error", err, 1);
    chk("werr_done", done, 0);
    chk("werr_busy", busy, 0);
    chk("werr_status", status, 0);
    repeat (10) @(negedge clk);
    chk("werr_req_idle", req, 0);
    chk("werr_ntxn", log_q.size(), 2);
    err_en = 0;

    lat = 1000;
    do_start(32'h7, 32'h2000, c0);
    for (int i = 0; i < 50 && !req; i++) @(negedge clk);
    chk("rst_mid_req", req, 1);
    chk("rst_mid_addr", addr, 32'hC8);
    rst = 1;
    @(negedge clk);
    chk("rst_mid_req_drop", req, 0);
    chk("rst_mid_busy", busy, 0);
    rst = 0;
    repeat (SD + 5) @(negedge clk);
    chk("rst_mid_stay_idle", req, 0);
    chk("rst_mid_idle_busy", busy, 0);

    lat = 0;
    eoc_dflt = 32'h0;
    do_start(32'h1, 32'h3000, c0);
`ifdef SAFETY_BOOT_TIMEOUT_EN
    wait_end(3000);
    chk("tmo_error", err, 1);
    chk("tmo_status", status, 31'h7FFF_FFFF);
    chk("tmo_busy", busy, 0);
    chk("tmo_done", done, 0);
`else
    repeat (2000) @(negedge clk);
    chk("notmo_busy", busy, 1);
    chk("notmo_error", err, 0);
    chk("notmo_done", done, 0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
